// File: rtl/issue_scheduler_pkg.sv
// Shared types for the issue scheduler: decode-queue item layout and execution-unit selector.
package issue_scheduler_pkg;

    typedef enum logic [1:0] {
        EXU_ALU = 2'd0,
        EXU_MUL = 2'd1,
        EXU_JMP = 2'd2,
        EXU_MEM = 2'd3
    } exu_e;

    typedef struct packed {
        logic [7:0]  uopcode;
        exu_e        exu_type;
        logic        has_rd;
        logic        has_rs1;
        logic        has_rs2;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } queue_item_t;

endpackage

// File: rtl/issue_scheduler.sv
// In-order single-issue scheduler: register-hazard scoreboard, multi-cycle unit occupancy,
// and a registered one-hot issue packet per popped decode-queue head.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int unsigned NUM_WB = 2,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  head_valid,
    input  queue_item_t           head_item,
    output logic                  head_pop,
    output logic [3:0]            iss_valid,
    output queue_item_t           iss_item,
    input  logic                  mul_done,
    input  logic                  mem_done,
    input  logic                  br_resolve,
    input  logic [NUM_WB-1:0]     wb_valid,
    input  logic [5*NUM_WB-1:0]   wb_rd,
    output logic [CNT_W-1:0]      stall_cycles
);

    typedef enum logic {
        UNIT_IDLE,
        UNIT_BUSY
    } unit_st_e;

    typedef enum logic {
        BR_IDLE,
        BR_WAIT
    } br_st_e;

    logic [31:0]      pending_q, pending_d;
    logic [31:0]      wb_clr;
    logic [31:0]      pend_set;
    unit_st_e         mul_st_q, mul_st_d;
    unit_st_e         mem_st_q, mem_st_d;
    br_st_e           br_st_q, br_st_d;
    logic [3:0]       iss_valid_q, iss_valid_d;
    queue_item_t      iss_item_q, iss_item_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic raw;
    logic waw;
    logic busy;
    logic pop;

    always_comb begin
        wb_clr = '0;
        for (int unsigned r = 1; r < 32; r++) begin
            for (int unsigned k = 0; k < NUM_WB; k++) begin
                if (wb_valid[k] && (wb_rd[5*k +: 5] == 5'(r))) begin
                    wb_clr[r] = 1'b1;
                end
            end
        end
    end

    // A writeback landing this cycle already releases the register for the head.
    always_comb begin
        raw  = (head_item.has_rs1 && pending_q[head_item.rs1] && !wb_clr[head_item.rs1])
            || (head_item.has_rs2 && pending_q[head_item.rs2] && !wb_clr[head_item.rs2]);
        waw  = head_item.has_rd && pending_q[head_item.rd] && !wb_clr[head_item.rd];
        busy = ((head_item.exu_type == EXU_MUL) && (mul_st_q == UNIT_BUSY) && !mul_done)
            || ((head_item.exu_type == EXU_MEM) && (mem_st_q == UNIT_BUSY) && !mem_done);
        pop  = head_valid && !raw && !waw && !busy && (br_st_q == BR_IDLE) && !rst;
    end

    assign head_pop = pop;

    always_comb begin
        pend_set = '0;
        if (pop && head_item.has_rd && (head_item.rd != 5'd0)) begin
            pend_set[head_item.rd] = 1'b1;
        end
        // Set is applied after clear: a same-edge writeback belongs to an older producer.
        pending_d    = (pending_q & ~wb_clr) | pend_set;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        mul_st_d = mul_st_q;
        if (pop && (head_item.exu_type == EXU_MUL)) begin
            mul_st_d = UNIT_BUSY;
        end else if ((mul_st_q == UNIT_BUSY) && mul_done) begin
            mul_st_d = UNIT_IDLE;
        end

        mem_st_d = mem_st_q;
        if (pop && (head_item.exu_type == EXU_MEM)) begin
            mem_st_d = UNIT_BUSY;
        end else if ((mem_st_q == UNIT_BUSY) && mem_done) begin
            mem_st_d = UNIT_IDLE;
        end

        br_st_d = br_st_q;
        if (pop && (head_item.exu_type == EXU_JMP)) begin
            br_st_d = BR_WAIT;
        end else if ((br_st_q == BR_WAIT) && br_resolve) begin
            br_st_d = BR_IDLE;
        end
    end

    always_comb begin
        iss_valid_d = '0;
        iss_item_d  = iss_item_q;
        if (pop) begin
            iss_valid_d[head_item.exu_type] = 1'b1;
            iss_item_d                      = head_item;
        end

        stall_d = stall_q;
        if (head_valid && !pop && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            mul_st_q    <= UNIT_IDLE;
            mem_st_q    <= UNIT_IDLE;
            br_st_q     <= BR_IDLE;
            iss_valid_q <= '0;
            iss_item_q  <= '0;
            stall_q     <= '0;
        end else begin
            pending_q   <= pending_d;
            mul_st_q    <= mul_st_d;
            mem_st_q    <= mem_st_d;
            br_st_q     <= br_st_d;
            iss_valid_q <= iss_valid_d;
            iss_item_q  <= iss_item_d;
            stall_q     <= stall_d;
        end
    end

    assign iss_valid    = iss_valid_q;
    assign iss_item     = iss_item_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: expected issue packets queued at drive time and
// matched against the registered issue strobe; narrow stall counter to reach saturation.
module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

    localparam int unsigned NUM_WB = 2;
    localparam int unsigned CNT_W  = 3;
    localparam int          SAT    = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 head_valid = 1'b0;
    queue_item_t          head_item = '0;
    logic                 head_pop;
    logic [3:0]           iss_valid;
    queue_item_t          iss_item;
    logic                 mul_done = 1'b0;
    logic                 mem_done = 1'b0;
    logic                 br_resolve = 1'b0;
    logic [NUM_WB-1:0]    wb_valid = '0;
    logic [5*NUM_WB-1:0]  wb_rd = '0;
    logic [CNT_W-1:0]     stall_cycles;

    int          checks = 0;
    int          failures = 0;
    int          exp_stall = 0;
    queue_item_t sb[$];
    logic        prev_pop = 1'b0;

    issue_scheduler #(
        .NUM_WB (NUM_WB),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .head_valid   (head_valid),
        .head_item    (head_item),
        .head_pop     (head_pop),
        .iss_valid    (iss_valid),
        .iss_item     (iss_item),
        .mul_done     (mul_done),
        .mem_done     (mem_done),
        .br_resolve   (br_resolve),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic queue_item_t mk(input exu_e t, input int rd, input int rs1,
                                       input int rs2, input logic [31:0] imm);
        queue_item_t it;
        it          = '0;
        it.uopcode  = imm[7:0] ^ 8'h5a;
        it.exu_type = t;
        it.has_rd   = (rd >= 0);
        it.has_rs1  = (rs1 >= 0);
        it.has_rs2  = (rs2 >= 0);
        it.rd       = (rd >= 0) ? 5'(rd) : 5'd0;
        it.rs1      = (rs1 >= 0) ? 5'(rs1) : 5'd0;
        it.rs2      = (rs2 >= 0) ? 5'(rs2) : 5'd0;
        it.imm      = imm;
        return it;
    endfunction

    task automatic drive(input queue_item_t it);
        head_valid = 1'b1;
        head_item  = it;
        sb.push_back(it);
    endtask

    task automatic wb(input int k, input int r);
        wb_valid[k]      = 1'b1;
        wb_rd[5*k +: 5]  = 5'(r);
    endtask

    // Sample mid-cycle, then advance to just after the next rising edge and drop pulses.
    task automatic cycle(input string tag, input logic e);
        @(negedge clk);
        chk({tag, "_stall"}, 64'(stall_cycles), 64'(exp_stall));
        chk({tag, "_pop"}, 64'(head_pop), 64'(e));
        if (head_valid && !e && exp_stall < SAT) exp_stall++;
        @(posedge clk);
        #1;
        wb_valid   = '0;
        mul_done   = 1'b0;
        mem_done   = 1'b0;
        br_resolve = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_pop || (iss_valid != 4'b0000)) begin
                chk("iss_strobe", 64'(|iss_valid), 64'(prev_pop));
            end
            if (iss_valid != 4'b0000) begin
                if (sb.size() == 0) begin
                    chk("iss_unexpected", 64'(iss_valid), 64'(0));
                end else begin
                    queue_item_t e;
                    e = sb.pop_front();
                    chk("iss_item", 64'(iss_item), 64'(e));
                    chk("iss_onehot", 64'(iss_valid), 64'(4'b0001 << e.exu_type));
                end
            end
        end
        prev_pop = head_pop && !rst;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with a valid head present that must not pop.
        head_valid = 1'b1;
        head_item  = mk(EXU_ALU, 1, -1, -1, 32'h1);
        @(negedge clk);
        chk("rst_iss_valid", 64'(iss_valid), 64'(0));
        chk("rst_iss_item", 64'(iss_item), 64'(0));
        chk("rst_stall", 64'(stall_cycles), 64'(0));
        chk("rst_pop", 64'(head_pop), 64'(0));
        @(posedge clk);
        #1;
        head_valid = 1'b0;
        rst        = 1'b0;

        // RAW stall released by a same-cycle writeback.
        drive(mk(EXU_ALU, 5, 0, -1, 32'd10));
        cycle("t2_addi", 1'b1);
        drive(mk(EXU_ALU, 6, 5, 1, 32'd0));
        cycle("t2_add_s0", 1'b0);
        cycle("t2_add_s1", 1'b0);
        cycle("t2_add_s2", 1'b0);
        wb(0, 5);
        cycle("t2_add_wb", 1'b1);
        head_valid = 1'b0;
        wb(1, 6);
        cycle("t2_idle", 1'b0);

        // Pop of a writer wins over a same-cycle writeback to that register.
        drive(mk(EXU_ALU, 7, -1, -1, 32'h7000));
        wb(0, 7);
        cycle("t5_lui7", 1'b1);
        drive(mk(EXU_ALU, 8, 7, 0, 32'd0));
        cycle("t5_rd7_s0", 1'b0);
        cycle("t5_rd7_s1", 1'b0);
        wb(1, 7);
        cycle("t5_rd7_wb", 1'b1);

        // x0 never becomes pending.
        drive(mk(EXU_ALU, 0, -1, -1, 32'h123));
        cycle("t6_lui0", 1'b1);
        drive(mk(EXU_ALU, 1, 0, 0, 32'd0));
        cycle("t6_add1", 1'b1);
        head_valid = 1'b0;
        cycle("t6_idle", 1'b0);

        // Mul occupancy; stall counter saturates during this section.
        drive(mk(EXU_MUL, 3, -1, -1, 32'd3));
        cycle("t3_mul3", 1'b1);
        drive(mk(EXU_MUL, 4, -1, -1, 32'd4));
        cycle("t3_mul4_s0", 1'b0);
        cycle("t3_mul4_s1", 1'b0);
        mul_done = 1'b1;
        cycle("t3_mul4_done", 1'b1);
        drive(mk(EXU_MUL, 9, -1, -1, 32'd9));
        cycle("t3_mul9_busy", 1'b0);
        mul_done = 1'b1;
        cycle("t3_mul9_done", 1'b1);
        head_valid = 1'b0;
        mul_done   = 1'b1;
        cycle("t3_drain", 1'b0);
        mul_done = 1'b1;
        cycle("t3_idle_done", 1'b0);
        drive(mk(EXU_MUL, 10, -1, -1, 32'd10));
        cycle("t3_mul10", 1'b1);

        // Single outstanding memory op.
        drive(mk(EXU_MEM, 11, 2, -1, 32'h40));
        cycle("mem_ld", 1'b1);
        drive(mk(EXU_MEM, -1, 2, 0, 32'h44));
        cycle("mem_st_busy", 1'b0);
        mem_done = 1'b1;
        cycle("mem_st_done", 1'b1);
        head_valid = 1'b0;
        mem_done   = 1'b1;
        cycle("mem_drain", 1'b0);

        // Branch blocks issue until the cycle after resolve.
        drive(mk(EXU_JMP, -1, 2, 0, 32'h80));
        cycle("t4_beq", 1'b1);
        drive(mk(EXU_ALU, 12, -1, -1, 32'd12));
        cycle("t4_w1", 1'b0);
        cycle("t4_w2", 1'b0);
        cycle("t4_w3", 1'b0);
        br_resolve = 1'b1;
        cycle("t4_w4_resolve", 1'b0);
        cycle("t4_a1", 1'b1);
        drive(mk(EXU_ALU, 13, -1, -1, 32'd13));
        br_resolve = 1'b1;
        cycle("t4_a2_idle_resolve", 1'b1);
        drive(mk(EXU_ALU, 14, -1, -1, 32'd14));
        cycle("t4_a3", 1'b1);

        // Asynchronous reset in the middle of a cycle with pending state and a busy mul.
        drive(mk(EXU_ALU, 20, -1, -1, 32'd20));
        cycle("t1_x20", 1'b1);
        drive(mk(EXU_ALU, 21, 20, 20, 32'd21));
        @(negedge clk);
        chk("t1_hold_pop", 64'(head_pop), 64'(0));
        #2;
        rst = 1'b1;
        #1;
        chk("t1_rst_iss_valid", 64'(iss_valid), 64'(0));
        chk("t1_rst_stall", 64'(stall_cycles), 64'(0));
        chk("t1_rst_pop", 64'(head_pop), 64'(0));
        exp_stall = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("t1_after_rst", 1'b1);
        drive(mk(EXU_MUL, 22, -1, -1, 32'd22));
        cycle("t1_mul_idle", 1'b1);
        head_valid = 1'b0;
        cycle("end_idle0", 1'b0);
        cycle("end_idle1", 1'b0);
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
